// File: rtl/serpent_keymix_sbox.sv
// Serpent round front end: key mixing followed by the bitsliced S-box layer,
// as a two-stage valid/ready pipeline that carries the round index and a user tag.
module serpent_keymix_sbox #(
  parameter int USER_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [127:0]      i_data,
  input  logic [127:0]      i_key,
  input  logic [4:0]        i_round,
  input  logic [USER_W-1:0] i_user,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [127:0]      o_data,
  output logic [4:0]        o_round,
  output logic [USER_W-1:0] o_user
);

  // Entry n of each table sits at bits [4n+3:4n].
  function automatic logic [63:0] sbox_table(input logic [2:0] sel);
    logic [63:0] tbl;
    case (sel)
      3'd0:    tbl = 64'hC907_24DE_B56A_1F83;
      3'd1:    tbl = 64'h43D6_8EB1_A509_72CF;
      3'd2:    tbl = 64'h25B0_4E1D_FAC3_9768;
      3'd3:    tbl = 64'hE57A_421D_369C_8BF0;
      3'd4:    tbl = 64'hD7E9_A452_6B0C_38F1;
      3'd5:    tbl = 64'h176D_8E30_C9A4_B25F;
      3'd6:    tbl = 64'h0A3D_F19E_B648_5C27;
      default: tbl = 64'h6539_AC47_B28E_0FD1;
    endcase
    return tbl;
  endfunction

  // Column j of the four words forms one nibble, X0 in the LSB position.
  function automatic logic [127:0] sbox_slice(input logic [2:0] sel, input logic [127:0] x);
    logic [63:0]  tbl;
    logic [3:0]   n;
    logic [3:0]   s;
    logic [127:0] y;
    tbl = sbox_table(sel);
    y   = '0;
    for (int j = 0; j < 32; j++) begin
      n = {x[j], x[32+j], x[64+j], x[96+j]};
      s = tbl[{n, 2'b00} +: 4];
      y[96+j] = s[0];
      y[64+j] = s[1];
      y[32+j] = s[2];
      y[j]    = s[3];
    end
    return y;
  endfunction

  logic              r_vld_p1;
  logic [127:0]      r_data_p1;
  logic [4:0]        r_round_p1;
  logic [USER_W-1:0] r_user_p1;
  logic              r_vld_p2;
  logic [127:0]      r_data_p2;
  logic [4:0]        r_round_p2;
  logic [USER_W-1:0] r_user_p2;

  logic              w_en_p2;
  logic              w_en_p1;
  logic [127:0]      w_sbox_p1;

  // An empty stage always loads, so bubbles are squeezed out during a stall.
  assign w_en_p2   = !r_vld_p2 || i_ready;
  assign w_en_p1   = !r_vld_p1 || w_en_p2;
  assign o_ready   = w_en_p1;
  assign w_sbox_p1 = sbox_slice(r_round_p1[2:0], r_data_p1);

  // Stage 1: key mixing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p1   <= 1'b0;
      r_data_p1  <= '0;
      r_round_p1 <= '0;
      r_user_p1  <= '0;
    end else if (w_en_p1) begin
      r_vld_p1 <= i_valid;
      if (i_valid) begin
        r_data_p1  <= i_data ^ i_key;
        r_round_p1 <= i_round;
        r_user_p1  <= i_user;
      end
    end
  end

  // Stage 2: substitution
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p2   <= 1'b0;
      r_data_p2  <= '0;
      r_round_p2 <= '0;
      r_user_p2  <= '0;
    end else if (w_en_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2  <= w_sbox_p1;
        r_round_p2 <= r_round_p1;
        r_user_p2  <= r_user_p1;
      end
    end
  end

  assign o_valid = r_vld_p2;
  assign o_data  = r_data_p2;
  assign o_round = r_round_p2;
  assign o_user  = r_user_p2;

endmodule

// File: tb/tb_serpent_keymix_sbox.sv
// Scoreboard bench for serpent_keymix_sbox: directed vectors, stall/bubble cases,
// randomized traffic against a word-level S-box reference, and reset flush.
module tb_serpent_keymix_sbox;
  localparam int USER_W = 8;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [127:0]      i_data;
  logic [127:0]      i_key;
  logic [4:0]        i_round;
  logic [USER_W-1:0] i_user;
  logic              o_valid;
  logic              i_ready;
  logic [127:0]      o_data;
  logic [4:0]        o_round;
  logic [USER_W-1:0] o_user;

  serpent_keymix_sbox #(.USER_W(USER_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_key(i_key), .i_round(i_round), .i_user(i_user),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_round(o_round), .o_user(o_user)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0]      d;
    logic [4:0]        r;
    logic [USER_W-1:0] u;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  int SB [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  function automatic logic [127:0] ref_sbox(input logic [127:0] d, input logic [127:0] kk,
                                            input logic [4:0] r);
    logic [127:0] t;
    logic [31:0]  x [4];
    logic [31:0]  y [4];
    int           sel, n, s;
    t   = d ^ kk;
    sel = int'(r) % 8;
    for (int w = 0; w < 4; w++) begin
      x[w] = t[127 - 32*w -: 32];
      y[w] = '0;
    end
    for (int j = 0; j < 32; j++) begin
      n = 0;
      for (int w = 0; w < 4; w++) n += int'(x[w][j]) << w;
      s = SB[sel][n];
      for (int w = 0; w < 4; w++) y[w][j] = ((s >> w) & 1) != 0;
    end
    return {y[0], y[1], y[2], y[3]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: inputs only change just after a rising edge, so the negedge view
  // tells exactly which handshakes the next edge will complete.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_d;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", {127'd0, o_valid}, 128'd1);
        chk("stall_data_hold", o_data, prev_d);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_beat", 128'd1, 128'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_data", o_data, e.d);
          chk("sb_round", {123'd0, o_round}, {123'd0, e.r});
          chk("sb_user", {{(128-USER_W){1'b0}}, o_user}, {{(128-USER_W){1'b0}}, e.u});
        end
      end
      if (i_valid && o_ready) begin
        e.d = ref_sbox(i_data, i_key, i_round);
        e.r = i_round;
        e.u = i_user;
        exp_q.push_back(e);
      end
      prev_stall = o_valid && !i_ready;
      prev_d     = o_data;
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [4:0] r,
                      input logic [USER_W-1:0] u);
    bit ok = 0;
    @(posedge clk); #1;
    i_data = d; i_key = k; i_round = r; i_user = u; i_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 128'd1, 128'd0);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [127:0] d, input logic [127:0] k,
                          input logic [4:0] r, input logic [127:0] exp_d);
    i_ready = 1'b1;
    send(d, k, r, 8'h00);
    @(negedge clk);
    chk({name, "_lat_early"}, {127'd0, o_valid}, 128'd0);
    @(negedge clk);
    chk({name, "_lat2_valid"}, {127'd0, o_valid}, 128'd1);
    chk({name, "_data"}, o_data, exp_d);
    chk({name, "_round"}, {123'd0, o_round}, {123'd0, r});
  endtask

  task automatic drain();
    bit ok = 0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 128'd1, 128'd0);
  endtask

  initial begin
    logic [13:0]  vs;
    logic [127:0] bd [3];
    logic [127:0] held;
    int           idx, sent;
    bit           acc;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_data = '0; i_key = '0; i_round = '0; i_user = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", {127'd0, o_valid}, 128'd0);
    chk("rst_o_ready", {127'd0, o_ready}, 128'd1);
    chk("rst_o_data", o_data, 128'd0);
    chk("rst_o_round_user", {115'd0, o_round, o_user}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    directed("zero_r0", '0, '0, 5'd0, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
    directed("ones_r8", '1, '1, 5'd8, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
    directed("ones_r7", '1, '0, 5'd7, 128'h00000000_FFFFFFFF_FFFFFFFF_00000000);
    drain();

    // Eight back-to-back beats must come out on eight consecutive cycles.
    vs = '0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      i_valid = (c < 8);
      i_data = '0; i_key = '0;
      i_round = 5'(c); i_user = USER_W'(c);
      @(negedge clk);
      vs[c] = o_valid;
    end
    chk("b2b_valid_pattern", {114'd0, vs}, {114'd0, 14'b00_1111_1111_00});
    drain();

    // Stall: three beats offered while downstream is blocked for five cycles.
    for (int b = 0; b < 3; b++) bd[b] = {$urandom, $urandom, $urandom, $urandom};
    i_ready = 1'b0;
    idx = 0; acc = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      i_valid = (idx < 3);
      if (idx < 3) begin
        i_data = bd[idx]; i_key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        i_round = 5'(idx + 3); i_user = USER_W'(8'hA0 + idx);
      end
      @(negedge clk);
      acc = i_valid && o_ready;
      if (c == 2) held = o_data;
    end
    chk("stall_accepted", 128'(idx), 128'd2);
    chk("stall_o_ready_low", {127'd0, o_ready}, 128'd0);
    chk("stall_o_data_stable", o_data, held);
    @(posedge clk); #1;
    i_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (o_ready) break;
    end
    drain();

    // Randomized traffic with random backpressure.
    sent = 0;
    for (int c = 0; c < 3000 && (sent < 300 || i_valid); c++) begin
      @(posedge clk); #1;
      if (i_valid && acc) i_valid = 1'b0;
      if (!i_valid && sent < 300 && $urandom_range(3) != 0) begin
        i_data  = {$urandom, $urandom, $urandom, $urandom};
        i_key   = {$urandom, $urandom, $urandom, $urandom};
        i_round = 5'($urandom_range(31));
        i_user  = USER_W'($urandom);
        i_valid = 1'b1;
        sent++;
      end
      i_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = i_valid && o_ready;
    end
    if (i_valid) chk("random_timeout", 128'd1, 128'd0);
    drain();

    // Reset with both stages full must discard everything in flight.
    i_ready = 1'b0;
    send(128'h1111, 128'h2222, 5'd1, 8'h11);
    send(128'h3333, 128'h4444, 5'd2, 8'h22);
    chk("full_o_ready_low", {127'd0, o_ready}, 128'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", {127'd0, o_valid}, 128'd0);
    chk("midrst_o_ready", {127'd0, o_ready}, 128'd1);
    chk("midrst_o_data", o_data, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_ready = 1'b1;
    vs = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vs[c] = o_valid;
    end
    chk("no_stale_after_rst", {114'd0, vs}, 128'd0);
    directed("post_rst", 128'hDEAD_BEEF, 128'h0, 5'd13,
             ref_sbox(128'hDEAD_BEEF, 128'h0, 5'd13));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
